// File: rtl/multi_reset_regf.sv
// rtl/multi_reset_regf.sv - channel enable/busy register file with per-channel soft-reset sequencing
// Optional wait-idle timeout with sticky flags: define MULTI_RESET_REGF_TIMEOUT_EN.
module multi_reset_regf #(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int SOFT_RST_CYC = 8,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              main_clk_i,
  input  logic              main_rst_i,
  input  logic              mem_ena_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              mem_wena_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic [NUM_CH-1:0] regf_ch_ena_rval_o,
  input  logic [NUM_CH-1:0] regf_ch_busy_rbus_i,
  input  logic              soft_rst_i,
  output logic [NUM_CH-1:0] soft_rst_o,
  output logic [NUM_CH-1:0] ch_idle_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_WAIT = 2'd2
  } ch_state_e;

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_BUSY = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SRST = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TMO  = ADDR_W'(3);
  localparam logic [7:0]        RST_LOAD = 8'(SOFT_RST_CYC);

  if (NUM_CH < 1 || NUM_CH > 16 || DATA_W < 16 || ADDR_W < 2 ||
      SOFT_RST_CYC < 1 || SOFT_RST_CYC > 255 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("multi_reset_regf: parameter out of range");
  end

  logic              rst;
  logic              wr_ctrl;
  logic              wr_srst;
  logic              wr_tmo;
  logic [NUM_CH-1:0] srst_req;
  logic [NUM_CH-1:0] tmo_clr;
  logic [NUM_CH-1:0] tmo_set;
  logic [NUM_CH-1:0] not_idle;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [7:0]        cnt_q   [NUM_CH];
  logic [7:0]        cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ctrl_q;
  logic [NUM_CH-1:0] ctrl_d;
  logic [NUM_CH-1:0] tmo_q;
  logic [NUM_CH-1:0] tmo_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              err_q;
  logic              err_d;

`ifdef MULTI_RESET_REGF_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC);
  logic [15:0]       tcnt_q  [NUM_CH];
  logic [15:0]       tcnt_d  [NUM_CH];
`endif

  // Only the low NUM_CH write-data bits carry meaning in any register.
  logic              unused_wdata;
  assign unused_wdata = ^mem_wdata_i;

  always_comb begin
    rst      = main_rst_i | soft_rst_i;
    wr_ctrl  = mem_ena_i && mem_wena_i && (mem_addr_i == A_CTRL);
    wr_srst  = mem_ena_i && mem_wena_i && (mem_addr_i == A_SRST);
    wr_tmo   = mem_ena_i && mem_wena_i && (mem_addr_i == A_TMO);
    srst_req = wr_srst ? mem_wdata_i[NUM_CH-1:0] : '0;
    tmo_clr  = wr_tmo  ? mem_wdata_i[NUM_CH-1:0] : '0;
  end

  // Channel FSM next state; a soft-reset request wins over every other transition.
  always_comb begin
    tmo_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
      tcnt_d[i]  = tcnt_q[i];
`endif
      if (srst_req[i]) begin
        state_d[i] = ST_RST;
        cnt_d[i]   = RST_LOAD;
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
        tcnt_d[i]  = '0;
`endif
      end else begin
        case (state_q[i])
          ST_RST: begin
            if (cnt_q[i] <= 8'd1) begin
              state_d[i] = ST_WAIT;
              cnt_d[i]   = '0;
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
              tcnt_d[i]  = TMO_LOAD;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          ST_WAIT: begin
            if (!regf_ch_busy_rbus_i[i]) begin
              state_d[i] = ST_IDLE;
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
              tcnt_d[i]  = '0;
            end else if (tcnt_q[i] <= 16'd1) begin
              state_d[i] = ST_IDLE;
              tcnt_d[i]  = '0;
              tmo_set[i] = 1'b1;
            end else begin
              tcnt_d[i] = tcnt_q[i] - 16'd1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  // CTRL bits of busy channels are frozen; entering RST clears the enable.
  always_comb begin
    ctrl_d = ctrl_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ctrl && (state_q[i] == ST_IDLE)) begin
        ctrl_d[i] = mem_wdata_i[i];
      end
      if (srst_req[i]) begin
        ctrl_d[i] = 1'b0;
      end
    end
    tmo_d = (tmo_q & ~tmo_clr) | tmo_set;
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (mem_ena_i) begin
      case (mem_addr_i)
        A_CTRL: if (!mem_wena_i) rdata_d = DATA_W'(ctrl_q);
        A_BUSY: begin
          if (mem_wena_i) err_d   = 1'b1;
          else            rdata_d = DATA_W'(regf_ch_busy_rbus_i);
        end
        A_SRST: if (!mem_wena_i) rdata_d = DATA_W'(not_idle);
        A_TMO:  if (!mem_wena_i) rdata_d = DATA_W'(tmo_q);
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      soft_rst_o[i] = (state_q[i] == ST_RST);
      ch_idle_o[i]  = (state_q[i] == ST_IDLE);
    end
    not_idle           = ~ch_idle_o;
    regf_ch_ena_rval_o = ctrl_q;
    mem_rdata_o        = rdata_q;
    mem_err_o          = err_q;
  end

  always_ff @(posedge main_clk_i) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
        tcnt_q[i]  <= '0;
`endif
      end
      ctrl_q  <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef MULTI_RESET_REGF_TIMEOUT_EN
        tcnt_q[i]  <= tcnt_d[i];
`endif
      end
      ctrl_q  <= ctrl_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_multi_reset_regf.sv
// tb/tb_multi_reset_regf.sv - directed scoreboard bench for multi_reset_regf
// Timeout expectations follow MULTI_RESET_REGF_TIMEOUT_EN.
module tb_multi_reset_regf;

  localparam int NUM_CH       = 4;
  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 32;
  localparam int SOFT_RST_CYC = 8;
  localparam int TIMEOUT_CYC  = 64;

`ifdef MULTI_RESET_REGF_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              main_rst_i;
  logic              mem_ena_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              mem_wena_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_err_o;
  logic [NUM_CH-1:0] regf_ch_ena_rval_o;
  logic [NUM_CH-1:0] regf_ch_busy_rbus_i;
  logic              soft_rst_i;
  logic [NUM_CH-1:0] soft_rst_o;
  logic [NUM_CH-1:0] ch_idle_o;

  always #5 clk = ~clk;

  multi_reset_regf #(
    .NUM_CH       (NUM_CH),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .SOFT_RST_CYC (SOFT_RST_CYC),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .main_clk_i          (clk),
    .main_rst_i          (main_rst_i),
    .mem_ena_i           (mem_ena_i),
    .mem_addr_i          (mem_addr_i),
    .mem_wena_i          (mem_wena_i),
    .mem_wdata_i         (mem_wdata_i),
    .mem_rdata_o         (mem_rdata_o),
    .mem_err_o           (mem_err_o),
    .regf_ch_ena_rval_o  (regf_ch_ena_rval_o),
    .regf_ch_busy_rbus_i (regf_ch_busy_rbus_i),
    .soft_rst_i          (soft_rst_i),
    .soft_rst_o          (soft_rst_o),
    .ch_idle_o           (ch_idle_o)
  );

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    bit                chk_rdata;
    string             tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus access: expectation queued at drive time, checked one cycle later.
  task automatic access(input bit wr, input int addr, input logic [DATA_W-1:0] wdata,
                        input logic [DATA_W-1:0] exp_rdata, input logic exp_err,
                        input string tag);
    exp_t e;
    @(negedge clk);
    mem_ena_i   = 1'b1;
    mem_wena_i  = wr;
    mem_addr_i  = addr[ADDR_W-1:0];
    mem_wdata_i = wdata;
    e.rdata     = exp_rdata;
    e.err       = exp_err;
    e.chk_rdata = !wr;
    e.tag       = tag;
    sb.push_back(e);
    @(negedge clk);
    mem_ena_i  = 1'b0;
    mem_wena_i = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_err"}, 32'(mem_err_o), 32'(e.err));
    if (e.chk_rdata) check({e.tag, "_rdata"}, mem_rdata_o, e.rdata);
  endtask

  initial begin
    main_rst_i          = 1'b1;
    soft_rst_i          = 1'b0;
    mem_ena_i           = 1'b0;
    mem_wena_i          = 1'b0;
    mem_addr_i          = '0;
    mem_wdata_i         = '0;
    regf_ch_busy_rbus_i = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    main_rst_i = 1'b0;
    check("rst_rdata", mem_rdata_o, 32'h0);
    check("rst_err", 32'(mem_err_o), 32'h0);
    check("rst_ena", 32'(regf_ch_ena_rval_o), 32'h0);
    check("rst_soft_rst", 32'(soft_rst_o), 32'h0);
    check("rst_idle", 32'(ch_idle_o), 32'hF);
    access(1'b0, 0, '0, 32'h0, 1'b0, "rst_rd_ctrl");

    // CTRL read/write and bad address
    access(1'b1, 0, 32'h0000_000A, '0, 1'b0, "ctrl_wr");
    check("ctrl_ena", 32'(regf_ch_ena_rval_o), 32'hA);
    access(1'b0, 0, '0, 32'h0000_000A, 1'b0, "ctrl_rd");
    access(1'b0, 7, '0, 32'h0, 1'b1, "bad_addr");
    @(negedge clk);
    check("noacc_rdata", mem_rdata_o, 32'h0);
    check("noacc_err", 32'(mem_err_o), 32'h0);

    // Soft reset of channel 1 with the core busy
    access(1'b1, 0, 32'hF, '0, 1'b0, "ctrl_wr_f");
    regf_ch_busy_rbus_i = 4'b0010;
    access(1'b1, 2, 32'h2, '0, 1'b0, "srst1_wr");
    check("srst1_ena", 32'(regf_ch_ena_rval_o), 32'hD);
    check("srst1_idle_rst", 32'(ch_idle_o), 32'hD);
    check("srst1_pulse_c1", 32'(soft_rst_o), 32'h2);
    for (int k = 2; k <= SOFT_RST_CYC; k++) begin
      @(negedge clk);
      check($sformatf("srst1_pulse_c%0d", k), 32'(soft_rst_o), 32'h2);
    end
    @(negedge clk);
    check("srst1_pulse_end", 32'(soft_rst_o), 32'h0);
    repeat (5) @(negedge clk);
    check("srst1_wait_idle", 32'(ch_idle_o), 32'hD);
    access(1'b0, 2, '0, 32'h2, 1'b0, "srst1_rd_srst");
    access(1'b0, 0, '0, 32'hD, 1'b0, "srst1_rd_ctrl");
    regf_ch_busy_rbus_i = 4'b0000;
    @(negedge clk);
    check("srst1_done_idle", 32'(ch_idle_o), 32'hF);
    access(1'b0, 2, '0, 32'h0, 1'b0, "srst1_rd_srst_done");

    // Retrigger of channel 0 at RST cycle 5, then CTRL write while it waits
    access(1'b1, 0, 32'hF, '0, 1'b0, "ctrl_wr_f2");
    regf_ch_busy_rbus_i = 4'b0001;
    access(1'b1, 2, 32'h1, '0, 1'b0, "srst0_wr");
    check("srst0_pulse_c1", 32'(soft_rst_o), 32'h1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("srst0_pulse_c%0d", k), 32'(soft_rst_o), 32'h1);
    end
    access(1'b1, 2, 32'h1, '0, 1'b0, "srst0_retrig");
    check("retrig_pulse_r1", 32'(soft_rst_o), 32'h1);
    for (int k = 2; k <= SOFT_RST_CYC; k++) begin
      @(negedge clk);
      check($sformatf("retrig_pulse_r%0d", k), 32'(soft_rst_o), 32'h1);
    end
    @(negedge clk);
    check("retrig_pulse_end", 32'(soft_rst_o), 32'h0);
    access(1'b1, 0, 32'hF, '0, 1'b0, "ctrl_wr_busy_ch");
    check("ctrl_ignore_ena", 32'(regf_ch_ena_rval_o), 32'hE);
    access(1'b0, 0, '0, 32'hE, 1'b0, "ctrl_ignore_rd");
    regf_ch_busy_rbus_i = 4'b0000;
    @(negedge clk);
    check("srst0_done_idle", 32'(ch_idle_o), 32'hF);

    // Global soft reset in RST cycle 3 of channel 2
    access(1'b1, 2, 32'h4, '0, 1'b0, "srst2_wr");
    @(negedge clk);
    @(negedge clk);
    soft_rst_i = 1'b1;
    check("mid_pulse_c3", 32'(soft_rst_o), 32'h4);
    @(negedge clk);
    soft_rst_i = 1'b0;
    check("mid_soft_rst", 32'(soft_rst_o), 32'h0);
    check("mid_idle", 32'(ch_idle_o), 32'hF);
    check("mid_ena", 32'(regf_ch_ena_rval_o), 32'h0);
    access(1'b1, 1, 32'hF, '0, 1'b1, "busy_wr_err");
    regf_ch_busy_rbus_i = 4'b0101;
    access(1'b0, 1, '0, 32'h5, 1'b0, "busy_rd");
    regf_ch_busy_rbus_i = 4'b0000;

    // Channel 2 with busy stuck high
    regf_ch_busy_rbus_i = 4'b0100;
    access(1'b1, 2, 32'h4, '0, 1'b0, "tmo_srst_wr");
    repeat (SOFT_RST_CYC + TIMEOUT_CYC - 1) @(negedge clk);
    check("tmo_last_wait", 32'(ch_idle_o), 32'hB);
    @(negedge clk);
    check("tmo_after", 32'(ch_idle_o), TMO_EN ? 32'hF : 32'hB);
    access(1'b0, 3, '0, TMO_EN ? 32'h4 : 32'h0, 1'b0, "tmo_rd");
    access(1'b1, 3, 32'h4, '0, 1'b0, "tmo_w1c");
    access(1'b0, 3, '0, 32'h0, 1'b0, "tmo_rd_clr");
    access(1'b0, 2, '0, TMO_EN ? 32'h0 : 32'h4, 1'b0, "tmo_rd_srst");
    regf_ch_busy_rbus_i = 4'b0000;
    @(negedge clk);
    check("tmo_final_idle", 32'(ch_idle_o), 32'hF);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
